regfile_cmd_sequencer: RTL and testbench

- Command-side master for the 64-bit, 32-entry RegisterFile (X31 reads as zero; writes commit on the Clk falling edge).
- Accepts read, write and bulk-init commands over a valid/ready handshake and drives the RegisterFile RA/RB/RW/BusW/RegWr ports.
- Returns the BusA/BusB read data over a valid/ready response channel.
- Used by the debug/load path and by bring-up benches to preload or inspect architectural registers without the datapath.

---
 rtl/regfile_cmd_sequencer.sv | 156 +++++++++++++++
 tb/tb_regfile_cmd_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_cmd_sequencer.sv
// Command-side master for the 32-entry register file: sequences read, write and bulk-init commands.
// Build option REGFILE_SEQ_PATTERN_INIT_EN: INIT writes Xn=n instead of zero.
module regfile_cmd_sequencer #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              Clk,
    input  logic              ResetL,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [1:0]        CmdOp,
    input  logic [ADDR_W-1:0] CmdRA,
    input  logic [ADDR_W-1:0] CmdRB,
    input  logic [ADDR_W-1:0] CmdRW,
    input  logic [DATA_W-1:0] CmdData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [DATA_W-1:0] RspA,
    output logic [DATA_W-1:0] RspB,
    output logic              RspErr,
    output logic              Busy,
    output logic [ADDR_W-1:0] RA,
    output logic [ADDR_W-1:0] RB,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    output logic              RegWr,
    input  logic [DATA_W-1:0] BusA,
    input  logic [DATA_W-1:0] BusB,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_INIT = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INIT  = 2'b10;

    localparam logic [ADDR_W-1:0] ZERO_IDX      = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_INIT_IDX = ADDR_W'(ZERO_REG - 1);

    state_t            state;
    logic [ADDR_W-1:0] rw_next;
    logic [DATA_W-1:0] init_word_next;

    assign rw_next = RW + 1'b1;

`ifdef REGFILE_SEQ_PATTERN_INIT_EN
    assign init_word_next = DATA_W'(rw_next);
`else
    assign init_word_next = '0;
`endif

    // Valid/ready: a command transfers on a rising edge with CmdValid && CmdReady, a
    // response on a rising edge with RspValid && RspReady; RspValid and the response
    // payload hold unchanged until that transfer.
    assign CmdReady  = (state == S_IDLE);
    assign Busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            state    <= S_IDLE;
            RA       <= '0;
            RB       <= '0;
            RW       <= '0;
            BusW     <= '0;
            RegWr    <= 1'b0;
            RspValid <= 1'b0;
            RspA     <= '0;
            RspB     <= '0;
            RspErr   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (CmdValid) begin
                        case (CmdOp)
                            OP_READ: begin
                                RA    <= CmdRA;
                                RB    <= CmdRB;
                                state <= S_RD;
                            end
                            OP_WRITE: begin
                                RW    <= CmdRW;
                                BusW  <= CmdData;
                                RegWr <= (CmdRW != ZERO_IDX);
                                state <= S_WR;
                            end
                            OP_INIT: begin
                                RW    <= '0;
                                BusW  <= '0;
                                RegWr <= 1'b1;
                                state <= S_INIT;
                            end
                            default: begin
                                RspA     <= '0;
                                RspB     <= '0;
                                RspErr   <= 1'b1;
                                RspValid <= 1'b1;
                                state    <= S_RSP;
                            end
                        endcase
                    end
                end
                S_RD: begin
                    RspA     <= BusA;
                    RspB     <= BusB;
                    RspErr   <= 1'b0;
                    RspValid <= 1'b1;
                    state    <= S_RSP;
                end
                S_WR: begin
                    // The register file committed on the falling edge of the previous cycle.
                    RegWr    <= 1'b0;
                    RspA     <= '0;
                    RspB     <= '0;
                    RspErr   <= (RW == ZERO_IDX);
                    RspValid <= 1'b1;
                    state    <= S_RSP;
                end
                S_INIT: begin
                    // RW doubles as the init counter and stops one short of the zero register.
                    if (RW == LAST_INIT_IDX) begin
                        RegWr    <= 1'b0;
                        RspA     <= '0;
                        RspB     <= '0;
                        RspErr   <= 1'b0;
                        RspValid <= 1'b1;
                        state    <= S_RSP;
                    end else begin
                        RW   <= rw_next;
                        BusW <= init_word_next;
                    end
                end
                S_RSP: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    RegWr    <= 1'b0;
                    RspValid <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Directed bench for regfile_cmd_sequencer with a behavioural 32x64 register file
// (X31 reads zero, writes commit on the falling edge).
module tb_regfile_cmd_sequencer;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

`ifdef REGFILE_SEQ_PATTERN_INIT_EN
    localparam bit PATTERN_INIT = 1'b1;
`else
    localparam bit PATTERN_INIT = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              ResetL = 1'b0;
    logic              CmdValid = 1'b0;
    logic              CmdReady;
    logic [1:0]        CmdOp = 2'b00;
    logic [ADDR_W-1:0] CmdRA = '0;
    logic [ADDR_W-1:0] CmdRB = '0;
    logic [ADDR_W-1:0] CmdRW = '0;
    logic [DATA_W-1:0] CmdData = '0;
    logic              RspValid;
    logic              RspReady = 1'b0;
    logic [DATA_W-1:0] RspA;
    logic [DATA_W-1:0] RspB;
    logic              RspErr;
    logic              Busy;
    logic [ADDR_W-1:0] RA;
    logic [ADDR_W-1:0] RB;
    logic [ADDR_W-1:0] RW;
    logic [DATA_W-1:0] BusW;
    logic              RegWr;
    logic [DATA_W-1:0] BusA;
    logic [DATA_W-1:0] BusB;
    logic [2:0]        dbg_state;

    regfile_cmd_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(31)) dut (
        .Clk(Clk), .ResetL(ResetL),
        .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp),
        .CmdRA(CmdRA), .CmdRB(CmdRB), .CmdRW(CmdRW), .CmdData(CmdData),
        .RspValid(RspValid), .RspReady(RspReady), .RspA(RspA), .RspB(RspB), .RspErr(RspErr),
        .Busy(Busy), .RA(RA), .RB(RB), .RW(RW), .BusW(BusW), .RegWr(RegWr),
        .BusA(BusA), .BusB(BusB), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    // ---------------- register file model ----------------
    logic [DATA_W-1:0] rf [0:31];
    logic [ADDR_W-1:0] wr_log [$];
    int                bad_wr = 0;

    initial for (int i = 0; i < 32; i++) rf[i] = '0;

    always @(negedge Clk) begin
        if (RegWr) begin
            wr_log.push_back(RW);
            if (RW == 5'd31) bad_wr++;
            else rf[RW] <= BusW;
        end
    end

    assign BusA = (RA == 5'd31) ? '0 : rf[RA];
    assign BusB = (RB == 5'd31) ? '0 : rf[RB];

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_exp(input int n);
        return PATTERN_INIT ? DATA_W'(n) : '0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                            input logic [ADDR_W-1:0] rw, input logic [DATA_W-1:0] data);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        CmdValid = 1'b1;
        CmdOp = op;
        CmdRA = ra;
        CmdRB = rb;
        CmdRW = rw;
        CmdData = data;
        while (!done && n < 20) begin
            if (CmdReady) done = 1'b1;
            @(posedge Clk);
            #1;
            n++;
        end
        CmdValid = 1'b0;
        check("cmd_accepted", {63'd0, done}, 64'd1);
    endtask

    // Called #1 after the accept edge; edges counts rising edges from accept to RspValid.
    task automatic get_rsp(output logic [DATA_W-1:0] a, output logic [DATA_W-1:0] b,
                           output logic err, output int edges);
        edges = 1;
        while (!RspValid && edges < 100) begin
            @(posedge Clk);
            #1;
            edges++;
        end
        check("rsp_valid_seen", {63'd0, RspValid}, 64'd1);
        a = RspA;
        b = RspB;
        err = RspErr;
        RspReady = 1'b1;
        @(posedge Clk);
        #1;
        RspReady = 1'b0;
        check("rsp_cleared", {63'd0, RspValid}, 64'd0);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                           output logic [DATA_W-1:0] a, output logic [DATA_W-1:0] b,
                           output logic err, output int edges);
        send_cmd(2'b00, ra, rb, 5'd0, 64'd0);
        get_rsp(a, b, err, edges);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0] a, b, held;
        logic              err;
        int                lat, bad, n;

        // reset for 3 cycles
        ResetL = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_regwr_during", {63'd0, RegWr}, 64'd0);
        ResetL = 1'b1;
        #1;
        check("rst_ra", {59'd0, RA}, 64'd0);
        check("rst_rb", {59'd0, RB}, 64'd0);
        check("rst_rw", {59'd0, RW}, 64'd0);
        check("rst_busw", BusW, 64'd0);
        check("rst_regwr", {63'd0, RegWr}, 64'd0);
        check("rst_rspvalid", {63'd0, RspValid}, 64'd0);
        check("rst_rspa", RspA, 64'd0);
        check("rst_rspb", RspB, 64'd0);
        check("rst_rsperr", {63'd0, RspErr}, 64'd0);
        check("rst_cmdready", {63'd0, CmdReady}, 64'd1);
        check("rst_busy", {63'd0, Busy}, 64'd0);
        @(posedge Clk);
        #1;

        // write X5 then read X5 / X31
        send_cmd(2'b01, 5'd0, 5'd0, 5'd5, 64'h12345678);
        check("wr5_regwr", {63'd0, RegWr}, 64'd1);
        check("wr5_rw", {59'd0, RW}, 64'd5);
        check("wr5_busw", BusW, 64'h12345678);
        get_rsp(a, b, err, lat);
        check("wr5_err", {63'd0, err}, 64'd0);
        check("wr5_rspa", a, 64'd0);
        check("wr5_regwr_after", {63'd0, RegWr}, 64'd0);
        do_read(5'd5, 5'd31, a, b, err, lat);
        check("rd5_a", a, 64'h12345678);
        check("rd5_b", b, 64'd0);
        check("rd5_err", {63'd0, err}, 64'd0);
        check("rd5_latency", 64'(lat), 64'd2);

        // write to zero register
        wr_log.delete();
        send_cmd(2'b01, 5'd0, 5'd0, 5'd31, 64'hABCD);
        check("wr31_regwr", {63'd0, RegWr}, 64'd0);
        get_rsp(a, b, err, lat);
        check("wr31_err", {63'd0, err}, 64'd1);
        check("wr31_no_pulse", 64'(wr_log.size()), 64'd0);
        do_read(5'd31, 5'd5, a, b, err, lat);
        check("rd31_a", a, 64'd0);
        check("rd31_b", b, 64'h12345678);

        // reserved op
        send_cmd(2'b11, 5'd0, 5'd0, 5'd0, 64'd0);
        get_rsp(a, b, err, lat);
        check("rsv_err", {63'd0, err}, 64'd1);
        check("rsv_a", a, 64'd0);
        check("rsv_latency", 64'(lat), 64'd1);

        // bulk init
        wr_log.delete();
        send_cmd(2'b10, 5'd0, 5'd0, 5'd0, 64'd0);
        get_rsp(a, b, err, lat);
        check("init_err", {63'd0, err}, 64'd0);
        check("init_pulses", 64'(wr_log.size()), 64'd31);
        bad = 0;
        for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] != 5'(i)) bad++;
        check("init_rw_seq", 64'(bad), 64'd0);
        do_read(5'd10, 5'd30, a, b, err, lat);
        check("init_x10", a, init_exp(10));
        check("init_x30", b, init_exp(30));
        do_read(5'd5, 5'd0, a, b, err, lat);
        check("init_x5", a, init_exp(5));
        check("init_x0", b, 64'd0);

        // response stall with a pending command
        send_cmd(2'b00, 5'd2, 5'd3, 5'd0, 64'd0);
        n = 0;
        while (!RspValid && n < 10) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("stall_valid_seen", {63'd0, RspValid}, 64'd1);
        held = RspA;
        check("stall_x2", held, init_exp(2));
        CmdValid = 1'b1;
        CmdOp = 2'b00;
        CmdRA = 5'd5;
        CmdRB = 5'd30;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            check("stall_valid", {63'd0, RspValid}, 64'd1);
            check("stall_a", RspA, init_exp(2));
            check("stall_cmdready", {63'd0, CmdReady}, 64'd0);
            check("stall_ra", {59'd0, RA}, 64'd2);
        end
        RspReady = 1'b1;
        @(posedge Clk);
        #1;
        RspReady = 1'b0;
        check("stall_consumed", {63'd0, RspValid}, 64'd0);
        check("stall_idle_ready", {63'd0, CmdReady}, 64'd1);
        @(posedge Clk);
        #1;
        CmdValid = 1'b0;
        check("pend_accepted", {63'd0, Busy}, 64'd1);
        check("pend_ra", {59'd0, RA}, 64'd5);
        get_rsp(a, b, err, lat);
        check("pend_x5", a, init_exp(5));
        check("pend_x30", b, init_exp(30));

        // reset in the middle of INIT
        send_cmd(2'b01, 5'd0, 5'd0, 5'd20, 64'hCAFE_0020_0000_BEEF);
        get_rsp(a, b, err, lat);
        send_cmd(2'b01, 5'd0, 5'd0, 5'd12, 64'h1212_1212);
        get_rsp(a, b, err, lat);
        send_cmd(2'b10, 5'd0, 5'd0, 5'd0, 64'd0);
        n = 0;
        while (!(RegWr && RW == 5'd12) && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("mid_init_rw12", {59'd0, RW}, 64'd12);
        ResetL = 1'b0;
        #1;
        check("mid_init_regwr", {63'd0, RegWr}, 64'd0);
        check("mid_init_busy", {63'd0, Busy}, 64'd0);
        @(posedge Clk);
        #1;
        ResetL = 1'b1;
        @(posedge Clk);
        #1;
        check("post_rst_ready", {63'd0, CmdReady}, 64'd1);
        do_read(5'd20, 5'd12, a, b, err, lat);
        check("post_rst_x20", a, 64'hCAFE_0020_0000_BEEF);
        check("post_rst_x12", b, 64'h1212_1212);
        do_read(5'd11, 5'd31, a, b, err, lat);
        check("post_rst_x11", a, init_exp(11));
        check("post_rst_x31", b, 64'd0);

        check("regwr_at_zero_reg", 64'(bad_wr), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
